reg_wb_queue: RTL

- Write-side front end for the multicycle core's 32x32 register file.
- Accepts completed results (destination index + 32-bit data) from ALU/load stages via valid/ready handshake and buffers them in a small in-order FIFO.
- Drains at most one entry per cycle into the register file write port (regwrite/rd/wd3) when the port is granted.
- Exposes a scoreboard so decode can see whether rs1/rs2 still have a queued, unretired write.

---
 rtl/reg_wb_queue.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/reg_wb_queue.sv
// -----------------------------------------------------------------------------
// reg_wb_queue
//
// Write-side front end for the 32x32 register file. Completed results
// (destination index + data) are accepted over a valid/ready handshake into
// a small in-order FIFO. The FIFO drains at most one entry per cycle into the
// register file write port whenever that port is granted. A scoreboard tells
// decode whether rs1/rs2 still have a queued write that has not retired.
//
// Optional feature: define WB_FWD_EN to add the rs1_fwd/rs2_fwd bypass
// outputs. Each one carries the data of the youngest queued write to that
// source register. Without the macro the ports do not exist and decode has
// to stall on busy.
//
// Parameters
//   DEPTH    FIFO entries, power of 2 in 2..16
//   PTR_W    log2(DEPTH)
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     producer handshake (in_ready == !full)
//   in_rd, in_data        destination index and result value
//   wb_en                 register file write port granted this cycle
//   regwrite, rd, wd3     register file write strobe, index and data
//   rs1, rs2              decode source indices
//   rs1_busy, rs2_busy    a queued entry targets rs1 / rs2
//   rs1_fwd, rs2_fwd      youngest queued data for rs1 / rs2 (WB_FWD_EN only)
//   count                 number of occupied entries
// -----------------------------------------------------------------------------
module reg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_data,

    input  logic             wb_en,
    output logic             regwrite,
    output logic [4:0]       rd,
    output logic [31:0]      wd3,

    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic             rs1_busy,
    output logic             rs2_busy,
`ifdef WB_FWD_EN
    output logic [31:0]      rs1_fwd,
    output logic [31:0]      rs2_fwd,
`endif
    output logic [PTR_W:0]   count
);

    // -------------------------------------------------------------------------
    // Storage and control state
    // -------------------------------------------------------------------------
    logic [4:0]        ent_rd_q   [DEPTH];
    logic [31:0]       ent_data_q [DEPTH];
    logic [DEPTH-1:0]  ent_vld_q, ent_vld_d;

    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W:0]    count_q, count_d;

    logic              empty;
    logic              full;
    logic              push;
    logic              pop;

    // Full and empty come from the occupancy count. The pointers alone cannot
    // tell the two states apart.
    assign empty    = (count_q == '0);
    assign full     = (count_q == (PTR_W+1)'(DEPTH));

    // A pop in this cycle does not free space until the next cycle. This keeps
    // in_ready independent of wb_en and removes any ready-to-grant comb path.
    assign in_ready = !full;

    // Writes to x0 complete the handshake but are never stored.
    assign push     = in_valid && !full && (in_rd != 5'd0);

    // The write strobe is suppressed during reset. The queued entries are
    // being discarded, so none of them may reach the register file.
    assign regwrite = wb_en && !empty && !reset;
    assign pop      = regwrite;

    assign rd       = empty ? 5'd0  : ent_rd_q[rptr_q];
    assign wd3      = empty ? 32'd0 : ent_data_q[rptr_q];
    assign count    = count_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        ent_vld_d = ent_vld_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;

        // Push and pop never hit the same slot. A pop needs at least one entry.
        // A push needs at least one free slot. So the two pointers differ
        // whenever both operations are active.
        if (pop) begin
            ent_vld_d[rptr_q] = 1'b0;
            rptr_d            = rptr_q + 1'b1;
        end
        if (push) begin
            ent_vld_d[wptr_q] = 1'b1;
            wptr_d            = wptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_vld_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            ent_vld_q <= ent_vld_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
        end
    end

    // The payload needs no reset. A slot is only observed while its valid
    // bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd_q[wptr_q]   <= in_rd;
            ent_data_q[wptr_q] <= in_data;
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    // The scoreboard is built from registered state only. The head that
    // retires this cycle still reports busy. An entry pushed this cycle only
    // becomes visible on the next cycle.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld_q[i] && (ent_rd_q[i] == rs1) && (rs1 != 5'd0))
                rs1_busy = 1'b1;
            if (ent_vld_q[i] && (ent_rd_q[i] == rs2) && (rs2 != 5'd0))
                rs2_busy = 1'b1;
        end
    end

`ifdef WB_FWD_EN
    // -------------------------------------------------------------------------
    // Forwarding
    // -------------------------------------------------------------------------
    // Slots are walked by age, from the head (oldest) toward the write
    // pointer (youngest). The last match wins, so the youngest matching write
    // is forwarded. Physical slot order is meaningless once the pointers
    // wrap.
    logic [PTR_W-1:0] fwd_slot;

    always_comb begin
        rs1_fwd  = 32'd0;
        rs2_fwd  = 32'd0;
        fwd_slot = rptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_slot = rptr_q + PTR_W'(k);
            if (ent_vld_q[fwd_slot] && (ent_rd_q[fwd_slot] == rs1) && (rs1 != 5'd0))
                rs1_fwd = ent_data_q[fwd_slot];
            if (ent_vld_q[fwd_slot] && (ent_rd_q[fwd_slot] == rs2) && (rs2 != 5'd0))
                rs2_fwd = ent_data_q[fwd_slot];
        end
    end
`endif

endmodule
